simon_core: RTL and testbench

SIMON_CORE -- requirements
Module: simon_core

---
 rtl/simon_core.sv | 146 ++++++++++++++
 tb/tb_simon_core.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_core.sv
// simon_core: iterative SIMON block cipher, one round per clock, with an
// on-chip key expansion that fills a T-entry round-key table after each key load.
module simon_core #(
  parameter int          N = 32,                    // word size in bits
  parameter int          M = 3,                     // key words
  parameter int          T = 42,                    // round count
  parameter logic [61:0] Z = 62'h3369F885192C0EF5   // z2, element 0 in bit 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [M*N-1:0]   key_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [2*N-1:0]   data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   data_out,
  output logic             busy
);

  localparam int CW = $clog2(T);

  typedef enum logic [2:0] {IDLE, KEYEXP, READY, RUN, DONE} state_t;

  state_t          state;
  logic [N-1:0]    rk [T];        // round-key table
  logic [CW-1:0]   cnt;           // key index in KEYEXP, round index in RUN
  logic [5:0]      zi;            // position in the Z sequence, wraps at 62
  logic [N-1:0]    x, y;          // working block halves
  logic            dec;           // latched mode
  logic            last;          // all T rounds applied, result pending

  logic            key_fire, blk_fire;
  logic [N-1:0]    ks_tmp, ks_new, round_key, nx, ny;

  function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int s);
    return (v << s) | (v >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int s);
    return (v >> s) | (v << (N - s));
  endfunction

  function automatic logic [N-1:0] f(input logic [N-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  // Handshake and status decode; a pending key load masks block acceptance.
  assign key_ready = (state == IDLE) || (state == READY);
  assign in_ready  = (state == READY) && !key_valid;
  assign out_valid = (state == DONE);
  assign busy      = (state == KEYEXP) || (state == RUN);
  assign key_fire  = key_valid && key_ready;
  assign blk_fire  = in_valid && in_ready;

  // Next expanded key word k[cnt] from the words already in the table.
  // NOTE: every variable gets a value on every path through always_comb, otherwise a latch is inferred.
  always_comb begin
    ks_tmp = ror(rk[cnt - CW'(1)], 3);
    if (M == 4) ks_tmp = ks_tmp ^ rk[cnt - CW'(3)];
    ks_tmp = ks_tmp ^ ror(ks_tmp, 1);
    ks_new = ~rk[cnt - CW'(M)] ^ ks_tmp ^ N'(Z[zi]) ^ N'(3);
  end

  // One SIMON round; decryption walks the key table backwards.
  always_comb begin
    round_key = rk[dec ? (CW'(T - 1) - cnt) : cnt];
    if (dec) begin
      nx = y;
      ny = x ^ f(y) ^ round_key;
    end else begin
      nx = y ^ f(x) ^ round_key;
      ny = x;
    end
  end

  // Round-key table: key words on load, one expanded word per KEYEXP cycle.
  // NOTE: the table has no reset; a key load plus KEYEXP always rewrites it before a block can read it.
  always_ff @(posedge clk) begin
    if (key_fire) begin
      for (int j = 0; j < M; j++) rk[j] <= key_in[j*N +: N];
    end else if (state == KEYEXP) begin
      rk[cnt] <= ks_new;
    end
  end

  // Control FSM and datapath registers.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      zi       <= '0;
      x        <= '0;
      y        <= '0;
      dec      <= 1'b0;
      last     <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (key_fire) begin
            state <= KEYEXP;
            cnt   <= CW'(M);
            zi    <= '0;
          end else if (blk_fire) begin
            state <= RUN;
            cnt   <= '0;
            last  <= 1'b0;
            dec   <= mode;
            x     <= data_in[2*N-1:N];
            y     <= data_in[N-1:0];
          end
        end
        KEYEXP: begin
          zi <= (zi == 6'd61) ? 6'd0 : zi + 6'd1;
          if (cnt == CW'(T - 1)) begin
            state <= READY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (last) begin
            data_out <= {x, y};
            state    <= DONE;
          end else begin
            x <= nx;
            y <= ny;
            if (cnt == CW'(T - 1)) last <= 1'b1;
            else                   cnt  <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= READY;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simon_core.sv
// tb_simon_core: vector table, randomized blocks against a reference model,
// and hand-written handshake/reset sequences for three SIMON configurations.
module tb_simon_core;

  localparam logic [61:0] Z2 = 62'h3369F885192C0EF5;
  localparam logic [61:0] Z3 = 62'h3C2CE51207A635DB;
  localparam logic [61:0] Z0 = 62'h19C3522FB386A45F;

  localparam logic [95:0] K1 = 96'h13121110_0b0a0908_03020100;
  localparam logic [63:0] PT = 64'h6f722067_6e696c63;
  localparam logic [63:0] CT = 64'h5ca2e27f_111a8fc8;

  logic clk = 1'b0;
  logic rst_n;

  // default instance: N=32, M=3, T=42
  logic        key_valid, key_ready, in_valid, in_ready, mode, out_valid, out_ready, busy;
  logic [95:0] key_in;
  logic [63:0] data_in, data_out;

  // N=32, M=4, T=44, z3
  logic         b_kv, b_kr, b_iv, b_ir, b_md, b_ov, b_or, b_busy;
  logic [127:0] b_key;
  logic [63:0]  b_din, b_dout;

  // N=16, M=4, T=32, z0
  logic        c_kv, c_kr, c_iv, c_ir, c_md, c_ov, c_or, c_busy;
  logic [63:0] c_key;
  logic [31:0] c_din, c_dout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  simon_core u_dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .in_valid(in_valid), .in_ready(in_ready), .mode(mode), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  simon_core #(.N(32), .M(4), .T(44), .Z(Z3)) u_z3 (
    .clk(clk), .rst_n(rst_n),
    .key_valid(b_kv), .key_ready(b_kr), .key_in(b_key),
    .in_valid(b_iv), .in_ready(b_ir), .mode(b_md), .data_in(b_din),
    .out_valid(b_ov), .out_ready(b_or), .data_out(b_dout), .busy(b_busy)
  );

  simon_core #(.N(16), .M(4), .T(32), .Z(Z0)) u_z0 (
    .clk(clk), .rst_n(rst_n),
    .key_valid(c_kv), .key_ready(c_kr), .key_in(c_key),
    .in_valid(c_iv), .in_ready(c_ir), .mode(c_md), .data_in(c_din),
    .out_valid(c_ov), .out_ready(c_or), .data_out(c_dout), .busy(c_busy)
  );

  // ---------------- reference model (plain arithmetic on 64-bit words) ----------------
  function automatic logic [63:0] wmask(input int n);
    return (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] v, input int s, input int n);
    logic [63:0] w;
    w = v & wmask(n);
    return ((w << s) | (w >> (n - s))) & wmask(n);
  endfunction

  function automatic logic [63:0] rf(input logic [63:0] v, input int n);
    return (rotl(v, 1, n) & rotl(v, 8, n)) ^ rotl(v, 2, n);
  endfunction

  function automatic logic [127:0] simon_ref(input int n, input int m, input int t,
                                             input logic [61:0] z, input logic [255:0] key,
                                             input logic [127:0] blk, input bit dec);
    logic [63:0] k [72];
    logic [63:0] mk, tmp, xv, yv, sv;
    mk = wmask(n);
    for (int i = 0; i < m; i++) k[i] = 64'(key >> (i * n)) & mk;
    for (int i = m; i < t; i++) begin
      tmp = rotl(k[i-1], n - 3, n);
      if (m == 4) tmp = tmp ^ k[i-3];
      tmp = tmp ^ rotl(tmp, n - 1, n);
      k[i] = (~k[i-m] & mk) ^ tmp ^ 64'(z[(i - m) % 62]) ^ 64'd3;
    end
    xv = 64'(blk >> n) & mk;
    yv = 64'(blk) & mk;
    if (!dec) begin
      for (int i = 0; i < t; i++) begin
        sv = xv; xv = yv ^ rf(xv, n) ^ k[i]; yv = sv;
      end
    end else begin
      for (int i = t - 1; i >= 0; i--) begin
        sv = yv; yv = xv ^ rf(yv, n) ^ k[i]; xv = sv;
      end
    end
    return (128'(xv) << n) | 128'(yv);
  endfunction

  function automatic logic [63:0] ref64(input logic [95:0] k, input logic [63:0] b, input bit d);
    return 64'(simon_ref(32, 3, 42, Z2, 256'(k), 128'(b), d));
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a key for one edge (caller ensures key_ready), then count KEYEXP cycles.
  task automatic load_key(input logic [95:0] k, output int cycles);
    key_in = k;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    cycles = 0;
    while (busy && cycles < 200) begin step(); cycles++; end
  endtask

  // Send one block with out_ready high; return result, accept-to-out_valid latency.
  task automatic run_block(input logic [63:0] d, input logic md, output logic [63:0] res, output int lat);
    int w;
    data_in = d;
    mode = md;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin step(); w++; end
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin step(); lat++; end
    res = data_out;
    step();
  endtask

  typedef struct {
    logic [95:0] key;
    logic [63:0] din;
    logic        md;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs [4];
  logic [95:0] cur_key, rkey;
  logic [63:0] res, res2, hold, pt;
  logic        md;
  int          cyc, lat;
  bit          ok_a, ok_b, ok_c;

  initial begin
    rst_n = 1'b0;
    key_valid = 0; in_valid = 0; mode = 0; out_ready = 1; key_in = '0; data_in = '0;
    b_kv = 0; b_iv = 0; b_md = 0; b_or = 1; b_key = '0; b_din = '0;
    c_kv = 0; c_iv = 0; c_md = 0; c_or = 1; c_key = '0; c_din = '0;

    vecs[0] = '{key: K1, din: PT, md: 1'b0, exp: CT};
    vecs[1] = '{key: K1, din: CT, md: 1'b1, exp: PT};
    vecs[2] = '{key: 96'h0, din: 64'h0, md: 1'b0, exp: ref64(96'h0, 64'h0, 1'b0)};
    vecs[3] = '{key: 96'hffffffff_00000000_ffffffff, din: 64'h01234567_89abcdef, md: 1'b1,
                exp: ref64(96'hffffffff_00000000_ffffffff, 64'h01234567_89abcdef, 1'b1)};

    // reset state
    #2;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_data_out", 128'(data_out), 128'(0));
    #20 rst_n = 1'b1;
    step();
    check("rst_key_ready", 128'(key_ready), 128'(1));
    check("rst_in_ready_busy", 128'({in_ready, busy}), 128'(0));

    // vector table
    cur_key = '1;
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].key !== cur_key) begin
        load_key(vecs[i].key, cyc);
        cur_key = vecs[i].key;
        check($sformatf("vec%0d_keyexp_cycles", i), 128'(cyc), 128'(39));
      end
      run_block(vecs[i].din, vecs[i].md, res, lat);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(43));
      check($sformatf("vec%0d_data", i), 128'(res), 128'(vecs[i].exp));
    end

    // randomized blocks against the model, plus round trips
    for (int r = 0; r < 9; r++) begin
      if (r % 3 == 0) begin
        cur_key = {$urandom, $urandom, $urandom};
        load_key(cur_key, cyc);
      end
      pt = {$urandom, $urandom};
      md = 1'($urandom_range(0, 1));
      run_block(pt, md, res, lat);
      check($sformatf("rand%0d", r), 128'(res), 128'(ref64(cur_key, pt, md)));
      if (r % 4 == 1) begin
        run_block(res, ~md, res2, lat);
        check($sformatf("rand%0d_roundtrip", r), 128'(res2), 128'(pt));
      end
    end

    // backpressure: out_ready low for 10 cycles in DONE
    load_key(K1, cyc);
    out_ready = 1'b0;
    data_in = PT; mode = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin step(); lat++; end
    hold = data_out;
    check("bp_data", 128'(hold), 128'(CT));
    ok_a = 1; ok_b = 1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (data_out !== hold || out_valid !== 1'b1) ok_a = 0;
      if (in_ready !== 1'b0 || key_ready !== 1'b0) ok_b = 0;
    end
    in_valid = 1'b0;
    check("bp_stable", 128'(ok_a), 128'(1));
    check("bp_ready_low", 128'(ok_b), 128'(1));
    out_ready = 1'b1;
    step();
    check("bp_release_ready", 128'({out_valid, in_ready, key_ready}), 128'(3'b011));
    data_in = CT; mode = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("b2b_accept_busy", 128'(busy), 128'(1));
    lat = 0;
    while (!out_valid && lat < 200) begin step(); lat++; end
    check("b2b_data", 128'(data_out), 128'(PT));
    step();

    // reset in RUN round 20
    data_in = PT; mode = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    #2 rst_n = 1'b0;
    #1;
    check("midrun_rst_outputs", 128'({out_valid, in_ready, busy}), 128'(0));
    check("midrun_rst_data_out", 128'(data_out), 128'(0));
    step();
    #3 rst_n = 1'b1;
    step();
    check("midrun_post_ready", 128'({key_ready, in_ready}), 128'(2'b10));
    in_valid = 1'b1;
    ok_c = 1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (out_valid !== 1'b0 || busy !== 1'b0) ok_c = 0;
    end
    in_valid = 1'b0;
    check("idle_ignores_block", 128'(ok_c), 128'(1));

    // key and block requested together in READY: key wins
    load_key(K1, cyc);
    rkey = {$urandom, $urandom, $urandom};
    key_in = rkey; key_valid = 1'b1;
    data_in = PT; in_valid = 1'b1; mode = 1'b0;
    #1;
    check("prio_in_ready", 128'({key_ready, in_ready}), 128'(2'b10));
    step();
    key_valid = 1'b0; in_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin step(); cyc++; end
    check("prio_keyexp_cycles", 128'(cyc), 128'(39));
    check("prio_no_out", 128'({out_valid, in_ready}), 128'(2'b01));
    run_block(PT, 1'b0, res, lat);
    check("prio_new_key_used", 128'(res), 128'(ref64(rkey, PT, 1'b0)));

    // N=32, M=4, T=44
    check("z3_key_ready", 128'(b_kr), 128'(1));
    b_key = 128'h1b1a1918_13121110_0b0a0908_03020100; b_kv = 1'b1;
    step();
    b_kv = 1'b0;
    cyc = 0;
    while (b_busy && cyc < 200) begin step(); cyc++; end
    check("z3_keyexp_cycles", 128'(cyc), 128'(40));
    b_din = 64'h656b696c_20646e75; b_md = 1'b0; b_iv = 1'b1;
    check("z3_in_ready", 128'(b_ir), 128'(1));
    step();
    b_iv = 1'b0;
    lat = 0;
    while (!b_ov && lat < 200) begin step(); lat++; end
    check("z3_latency", 128'(lat), 128'(45));
    check("z3_enc", 128'(b_dout), 128'(64'h44c8fc20_b9dfa07a));
    check("z3_enc_model", 128'(b_dout),
          simon_ref(32, 4, 44, Z3, 256'(b_key), 128'(b_din), 1'b0));
    step();

    // N=16, M=4, T=32
    check("z0_key_ready", 128'(c_kr), 128'(1));
    c_key = 64'h1918_1110_0908_0100; c_kv = 1'b1;
    step();
    c_kv = 1'b0;
    cyc = 0;
    while (c_busy && cyc < 200) begin step(); cyc++; end
    check("z0_keyexp_cycles", 128'(cyc), 128'(28));
    for (int d = 0; d < 2; d++) begin
      c_din = (d == 0) ? 32'h6565_6877 : 32'hc69b_e9bb;
      c_md = 1'(d); c_iv = 1'b1;
      check($sformatf("z0_in_ready%0d", d), 128'(c_ir), 128'(1));
      step();
      c_iv = 1'b0;
      lat = 0;
      while (!c_ov && lat < 200) begin step(); lat++; end
      check($sformatf("z0_latency%0d", d), 128'(lat), 128'(33));
      check($sformatf("z0_data%0d", d), 128'(c_dout),
            128'((d == 0) ? 32'hc69b_e9bb : 32'h6565_6877));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
